rc4_task_ctrl: RTL
==================

// Module: rc4_task_ctrl
// PURPOSE
//   Top-level sequencer for the RC4 datapath. On a one-cycle start pulse (from the
//   button synchroniser) it latches the key and runs S-array init, key schedule
//   (KSA) and keystream/decrypt (PRGA) in order, using a start/done handshake with
//   each task. It also owns the single S-memory port, granting it to the active task.
// PARAMETERS
//   ADDR_W      8        S-memory address width
//   DATA_W      8        S-memory data width
//   KEY_W       24       key width (switch inputs)
//   TIMEOUT_CYC 4096     max cycles in any WAIT state before error; 0 disables
// PORTS
//   clk          in   1       system clock, all logic on rising edge
//   rst          in   1       synchronous reset, active high
//   start        in   1       one-cycle pulse request to run all three phases
//   key_in       in   KEY_W   key value, sampled on accepted start
//   key          out  KEY_W   latched key driven to KSA/PRGA
//   init_start   out  1       one-cycle pulse: begin S init
//   init_done    in   1       init task finished (level or pulse)
//   ksa_start    out  1       one-cycle pulse: begin KSA
//   ksa_done     in   1       KSA finished
//   prga_start   out  1       one-cycle pulse: begin PRGA
//   prga_done    in   1       PRGA finished
//   {init,ksa,prga}_addr/_wrdata/_wren  in  ADDR_W/DATA_W/1  per-task S-mem request
//   s_addr       out  ADDR_W  muxed S-memory address
//   s_wrdata     out  DATA_W  muxed S-memory write data
//   s_wren       out  1       muxed S-memory write enable
//   phase        out  2       owner: 0 none, 1 init, 2 KSA, 3 PRGA
//   busy         out  1       high from accepted start until DONE/ERROR
//   done         out  1       all phases complete; held until next start or rst
//   error        out  1       a phase timed out; held until next start or rst
// BEHAVIOUR
//   - States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, DONE, ERROR.
//   - rst: state IDLE, key=0, phase=0, all *_start/busy/done/error/s_wren=0, timer=0.
//   - IDLE/DONE/ERROR + start=1 at edge N: key<=key_in, state INIT_GO; init_start
//     high only during cycle N+1; done/error clear at edge N.
//   - X_GO -> X_WAIT unconditionally (start pulse exactly one cycle wide).
//   - X_WAIT: x_done=1 at an edge -> next GO (INIT->KSA->PRGA) or DONE after PRGA.
//     Zero-cycle tasks: x_done high in first WAIT cycle is accepted.
//   - done inputs are sampled only in their own WAIT state; any other done ignored.
//   - start while busy (GO/WAIT states) is ignored; key not re-latched.
//   - Timer clears on entry to each GO state, increments each WAIT cycle; if it
//     reaches TIMEOUT_CYC-1 without done -> ERROR (done wins if same edge).
//   - phase: 1 in INIT_GO/WAIT, 2 in KSA_GO/WAIT, 3 in PRGA_GO/WAIT, else 0.
//   - Memory mux combinational on registered phase: phase selects that task's
//     addr/wrdata/wren; phase 0 -> s_addr=0, s_wrdata=0, s_wren=0. Non-owner
//     wren never reaches memory.
//   - busy = state in {GO,WAIT}; done = (state==DONE); error = (state==ERROR).
//   - rst mid-phase: next cycle IDLE, s_wren=0, no start pulses issued.
// TESTING
//   1 rst, key_in=24'h000249, start pulse; dones 5/20/30 cycles after each start ->
//     key=24'h000249, one pulse each of init/ksa/prga_start in order, done=1, busy=0.
//   2 During KSA_WAIT drive init_done=1 and prga_done=1 -> ignored, phase stays 2.
//   3 start pulse in PRGA_WAIT with key_in=24'hFFFFFF -> ignored, key unchanged,
//     no extra init_start.
//   4 TIMEOUT_CYC=16, withhold ksa_done -> error=1 after 16 WAIT cycles, s_wren=0;
//     new start clears error and restarts at INIT.
//   5 phase=1, init_wren=1 addr=8'h10, ksa_wren=1 addr=8'h20 -> s_addr=8'h10,
//     s_wren=1; in IDLE all task wren=1 -> s_wren=0.
//   6 rst asserted in PRGA_WAIT -> IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/rc4_task_ctrl.sv
// Top-level RC4 sequencer: runs S-array init, KSA and PRGA in order via start/done
// handshakes, and grants the single S-memory port to whichever task is active.
module rc4_task_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned KEY_W       = 24,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [KEY_W-1:0]  key_i,
    output logic [KEY_W-1:0]  key_o,
    output logic              init_start_o,
    input  logic              init_done_i,
    output logic              ksa_start_o,
    input  logic              ksa_done_i,
    output logic              prga_start_o,
    input  logic              prga_done_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [DATA_W-1:0] init_wrdata_i,
    input  logic              init_wren_i,
    input  logic [ADDR_W-1:0] ksa_addr_i,
    input  logic [DATA_W-1:0] ksa_wrdata_i,
    input  logic              ksa_wren_i,
    input  logic [ADDR_W-1:0] prga_addr_i,
    input  logic [DATA_W-1:0] prga_wrdata_i,
    input  logic              prga_wren_i,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wrdata_o,
    output logic              s_wren_o,
    output logic [1:0]        phase_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned TimerW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [3:0] {
        StIdle, StInitGo, StInitWait, StKsaGo, StKsaWait,
        StPrgaGo, StPrgaWait, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        phase_q, phase_d;
    logic              timeout_hit;

    // A zero TIMEOUT_CYC disables the watchdog; the timer then simply wraps.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TimerW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        timer_d = '0;
        case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d = StInitGo;
                    key_d   = key_i;
                end
            end
            StInitGo: state_d = StInitWait;
            StKsaGo:  state_d = StKsaWait;
            StPrgaGo: state_d = StPrgaWait;
            StInitWait: begin
                if (init_done_i)      state_d = StKsaGo;
                else if (timeout_hit) state_d = StError;
                else                  timer_d = timer_q + 1'b1;
            end
            StKsaWait: begin
                if (ksa_done_i)       state_d = StPrgaGo;
                else if (timeout_hit) state_d = StError;
                else                  timer_d = timer_q + 1'b1;
            end
            StPrgaWait: begin
                if (prga_done_i)      state_d = StDone;
                else if (timeout_hit) state_d = StError;
                else                  timer_d = timer_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Owner is registered alongside the state so the memory mux sees a clean select.
    always_comb begin
        phase_d = 2'd0;
        case (state_d)
            StInitGo, StInitWait: phase_d = 2'd1;
            StKsaGo, StKsaWait:   phase_d = 2'd2;
            StPrgaGo, StPrgaWait: phase_d = 2'd3;
            default:              phase_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            key_q   <= '0;
            timer_q <= '0;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        s_addr_o   = '0;
        s_wrdata_o = '0;
        s_wren_o   = 1'b0;
        case (phase_q)
            2'd1: begin
                s_addr_o   = init_addr_i;
                s_wrdata_o = init_wrdata_i;
                s_wren_o   = init_wren_i;
            end
            2'd2: begin
                s_addr_o   = ksa_addr_i;
                s_wrdata_o = ksa_wrdata_i;
                s_wren_o   = ksa_wren_i;
            end
            2'd3: begin
                s_addr_o   = prga_addr_i;
                s_wrdata_o = prga_wrdata_i;
                s_wren_o   = prga_wren_i;
            end
            default: begin
                s_addr_o   = '0;
                s_wrdata_o = '0;
                s_wren_o   = 1'b0;
            end
        endcase
    end

    assign key_o        = key_q;
    assign phase_o      = phase_q;
    assign init_start_o = (state_q == StInitGo);
    assign ksa_start_o  = (state_q == StKsaGo);
    assign prga_start_o = (state_q == StPrgaGo);
    assign busy_o       = (state_q == StInitGo) || (state_q == StInitWait) ||
                          (state_q == StKsaGo)  || (state_q == StKsaWait)  ||
                          (state_q == StPrgaGo) || (state_q == StPrgaWait);
    assign done_o       = (state_q == StDone);
    assign error_o      = (state_q == StError);

endmodule
